// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - state encodings and latency helper shared by the modular exponentiation engine
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REDUCE,
    MUL_R,
    MUL_B,
    FIN
  } rsa_state_e;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_RUN,
    MM_DONE
  } mm_state_e;

  // Accept-to-done cycles of the constant-time build: CHECK + (REDUCE + 2 per bit) multiplies + FIN
  function automatic int unsigned rsa_exp_latency(input int unsigned width,
                                                  input int unsigned exp_width);
    return 2 + (2 * exp_width + 1) * (width + 2);
  endfunction

endpackage

// File: rtl/rsa_mod_mult.sv
// rtl/rsa_mod_mult.sv - interleaved shift-add modular multiplier, p = a*b mod n, a scanned MSB first
// Takes WIDTH+2 cycles per product: launch, WIDTH steps, writeback (o_done high for one cycle).
module rsa_mod_mult
  import rsa_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_n,
  output logic             o_done,
  output logic [WIDTH-1:0] o_p
);

  localparam int CW = $clog2(WIDTH);

  mm_state_e        r_state, w_state_nx;
  logic [WIDTH+1:0] r_acc;
  logic [WIDTH-1:0] r_a, r_b, r_n;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH+1:0] w_sum, w_n1, w_n2, w_step;

  // acc < n holds between steps, so 2*acc + b < 3n and one conditional subtract restores it
  always_comb begin
    w_n1  = {2'b00, r_n};
    w_n2  = {1'b0, r_n, 1'b0};
    w_sum = (r_acc << 1) + (r_a[WIDTH-1] ? {2'b00, r_b} : '0);
    if (w_sum >= w_n2)
      w_step = w_sum - w_n2;
    else if (w_sum >= w_n1)
      w_step = w_sum - w_n1;
    else
      w_step = w_sum;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_state <= MM_IDLE;
    else
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      MM_IDLE: if (i_start) w_state_nx = MM_RUN;
      MM_RUN:  if (r_cnt == '0) w_state_nx = MM_DONE;
      MM_DONE: w_state_nx = MM_IDLE;
      default: w_state_nx = MM_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_n   <= '0;
      r_cnt <= '0;
    end else if (r_state == MM_IDLE && i_start) begin
      r_acc <= '0;
      r_a   <= i_a;
      r_b   <= i_b;
      r_n   <= i_n;
      r_cnt <= CW'(WIDTH - 1);
    end else if (r_state == MM_RUN) begin
      r_acc <= w_step;
      r_a   <= {r_a[WIDTH-2:0], 1'b0};
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_state == MM_DONE);
  assign o_p    = r_acc[WIDTH-1:0];

endmodule

// File: rtl/rsa_mod_exp_engine.sv
// rtl/rsa_mod_exp_engine.sv - base^exponent mod modulus, right-to-left binary scan on one shared multiplier
// RSA_EXP_SKIP_EN: skip zero-bit MUL_R, stop after the top set bit, add o_cycle_count.
module rsa_mod_exp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_base,
  input  logic [EXP_WIDTH-1:0] i_exponent,
  input  logic [WIDTH-1:0]     i_modulus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [WIDTH-1:0]     o_result
`ifdef RSA_EXP_SKIP_EN
  ,
  output logic [31:0]          o_cycle_count
`endif
);

  rsa_state_e           r_state, w_state_nx;
  logic [WIDTH-1:0]     r_base, r_mod, r_r, r_b, r_result;
  logic [EXP_WIDTH-1:0] r_exp, w_exp_sh;
  logic                 r_bad, r_launch, w_launch_nx, r_busy, r_done, r_err;
  logic                 w_accept, w_mm_done;
  logic [WIDTH-1:0]     w_mm_a, w_mm_b, w_mm_p;

  assign w_accept = (r_state == IDLE) && i_start;
  assign w_exp_sh = r_exp >> 1;

`ifndef RSA_EXP_SKIP_EN
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  logic [IW-1:0] r_idx;
  logic          w_last_bit;
  assign w_last_bit = (r_idx == IW'(EXP_WIDTH - 1));
`endif

  always_comb begin
    w_mm_a = r_b;
    w_mm_b = r_b;
    case (r_state)
      REDUCE: begin
        w_mm_a = r_base;
        w_mm_b = WIDTH'(1);
      end
      MUL_R: begin
        w_mm_a = r_r;
        w_mm_b = r_b;
      end
      default: ;
    endcase
  end

  rsa_mod_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .i_clk  (i_clk),
    .i_rst  (i_reset),
    .i_start(r_launch),
    .i_a    (w_mm_a),
    .i_b    (w_mm_b),
    .i_n    (r_mod),
    .o_done (w_mm_done),
    .o_p    (w_mm_p)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_launch_nx = 1'b0;
    case (r_state)
      IDLE:  if (i_start) w_state_nx = CHECK;
      CHECK: w_state_nx = (r_mod < WIDTH'(2)) ? FIN : REDUCE;
      REDUCE: if (w_mm_done) begin
`ifdef RSA_EXP_SKIP_EN
        if (r_exp == '0)
          w_state_nx = FIN;
        else
          w_state_nx = r_exp[0] ? MUL_R : MUL_B;
`else
        w_state_nx = MUL_R;
`endif
      end
      MUL_R: if (w_mm_done) begin
`ifdef RSA_EXP_SKIP_EN
        w_state_nx = (w_exp_sh == '0) ? FIN : MUL_B;
`else
        w_state_nx = MUL_B;
`endif
      end
      MUL_B: if (w_mm_done) begin
`ifdef RSA_EXP_SKIP_EN
        w_state_nx = w_exp_sh[0] ? MUL_R : MUL_B;
`else
        w_state_nx = w_last_bit ? FIN : MUL_R;
`endif
      end
      FIN:     w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
    // Every entry into a multiply state, including MUL_B -> MUL_B, launches a fresh product
    if ((w_state_nx inside {REDUCE, MUL_R, MUL_B}) && (r_state == CHECK || w_mm_done))
      w_launch_nx = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_base   <= '0;
      r_mod    <= '0;
      r_exp    <= '0;
      r_r      <= '0;
      r_b      <= '0;
      r_bad    <= 1'b0;
      r_launch <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
`ifndef RSA_EXP_SKIP_EN
      r_idx    <= '0;
`endif
    end else begin
      r_launch <= w_launch_nx;
      r_done   <= (r_state == FIN);
      if (w_accept) begin
        r_base   <= i_base;
        r_exp    <= i_exponent;
        r_mod    <= i_modulus;
        r_r      <= WIDTH'(1);
        r_busy   <= 1'b1;
        r_err    <= 1'b0;
        r_result <= '0;
`ifndef RSA_EXP_SKIP_EN
        r_idx    <= '0;
`endif
      end
      case (r_state)
        CHECK:  r_bad <= (r_mod < WIDTH'(2));
        REDUCE: if (w_mm_done) r_b <= w_mm_p;
        MUL_R:  if (w_mm_done && r_exp[0]) r_r <= w_mm_p;
        MUL_B: if (w_mm_done) begin
          r_b   <= w_mm_p;
          r_exp <= w_exp_sh;
`ifndef RSA_EXP_SKIP_EN
          r_idx <= r_idx + 1'b1;
`endif
        end
        FIN: begin
          r_busy   <= 1'b0;
          r_err    <= r_bad;
          r_result <= r_bad ? '0 : r_r;
        end
        default: ;
      endcase
    end
  end

`ifdef RSA_EXP_SKIP_EN
  logic [31:0] r_cyc, r_cycle_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cyc         <= '0;
      r_cycle_count <= '0;
    end else begin
      if (w_accept)
        r_cyc <= '0;
      else if (r_busy)
        r_cyc <= r_cyc + 32'd1;
      if (r_state == FIN)
        r_cycle_count <= r_cyc + 32'd1;
    end
  end

  assign o_cycle_count = r_cycle_count;
`endif

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_result = r_result;

endmodule

// File: tb/tb_rsa_mod_exp_engine.sv
// tb/tb_rsa_mod_exp_engine.sv - directed vectors for rsa_mod_exp_engine (16-bit core plus 256-bit encrypt/decrypt chain)
module tb_rsa_mod_exp_engine;

  localparam int W  = 16;
  localparam int E  = 16;
  localparam int BW = 256;
  localparam int BE = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, busy, done, err;
  logic [W-1:0]  base, modulus, result;
  logic [E-1:0]  exponent;
`ifdef RSA_EXP_SKIP_EN
  logic [31:0]   cyc, enc_cyc, dec_cyc;
`endif

  logic          enc_start, enc_busy, enc_done, enc_err;
  logic          dec_start, dec_busy, dec_done, dec_err;
  logic [BW-1:0] enc_base, enc_mod, enc_result, dec_result;
  logic [BE-1:0] enc_exp, dec_exp;

  rsa_mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(E)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_base(base), .i_exponent(exponent),
    .i_modulus(modulus), .o_busy(busy), .o_done(done), .o_err(err), .o_result(result)
`ifdef RSA_EXP_SKIP_EN
    , .o_cycle_count(cyc)
`endif
  );

  rsa_mod_exp_engine #(.WIDTH(BW), .EXP_WIDTH(BE)) u_enc (
    .i_clk(clk), .i_reset(rst), .i_start(enc_start), .i_base(enc_base), .i_exponent(enc_exp),
    .i_modulus(enc_mod), .o_busy(enc_busy), .o_done(enc_done), .o_err(enc_err), .o_result(enc_result)
`ifdef RSA_EXP_SKIP_EN
    , .o_cycle_count(enc_cyc)
`endif
  );

  rsa_mod_exp_engine #(.WIDTH(BW), .EXP_WIDTH(BE)) u_dec (
    .i_clk(clk), .i_reset(rst), .i_start(dec_start), .i_base(enc_result), .i_exponent(dec_exp),
    .i_modulus(enc_mod), .o_busy(dec_busy), .o_done(dec_done), .o_err(dec_err), .o_result(dec_result)
`ifdef RSA_EXP_SKIP_EN
    , .o_cycle_count(dec_cyc)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic launch(input logic [W-1:0] b, input logic [E-1:0] e, input logic [W-1:0] m);
    @(negedge clk);
    base = b; exponent = e; modulus = m; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] b, input logic [E-1:0] e,
                        input logic [W-1:0] m, input logic [W-1:0] want, input logic want_err,
                        input int want_lat);
    int lat;
    launch(b, e, m);
    chk({tag, "_busy"}, busy, 1'b1);
    wait_done(lat);
    chk({tag, "_result"}, result, want);
    chk({tag, "_err"}, err, want_err);
    if (want_lat > 0) chk({tag, "_latency"}, lat, want_lat);
  endtask

  int lat_ct;
  int seen;
  int t;

  initial begin
    // 596 = 2 + 33*18; skip builds only check latency where the path is data-independent
`ifdef RSA_EXP_SKIP_EN
    lat_ct = 0;
`else
    lat_ct = 596;
`endif
    rst = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    enc_start = 1'b0; dec_start = 1'b0; enc_base = '0; enc_exp = '0; enc_mod = '0; dec_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_result", result, '0);
    @(negedge clk);
    rst = 1'b0;

    run_op("c1", 16'd7, 16'd13, 16'd11, 16'd2, 1'b0, lat_ct);
`ifdef RSA_EXP_SKIP_EN
    chk("skip_cycle_count", cyc, 32'd128);
    chk("skip_faster", cyc < 32'd596, 1'b1);
`endif
    run_op("c2", 16'd100, 16'd3, 16'd13, 16'd1, 1'b0, lat_ct);
    run_op("c3", 16'd5, 16'd0, 16'd7, 16'd1, 1'b0, lat_ct);
    run_op("mod1", 16'd9, 16'd5, 16'd1, 16'd0, 1'b1, 2);
    run_op("mod0", 16'd9, 16'd5, 16'd0, 16'd0, 1'b1, 2);
    run_op("max_base", 16'hFFFF, 16'd2, 16'hFFFE, 16'd1, 1'b0, lat_ct);
    run_op("pow2_15", 16'd2, 16'd15, 16'hFFFF, 16'h8000, 1'b0, lat_ct);
    run_op("pow2_16", 16'd2, 16'd16, 16'hFFFF, 16'd1, 1'b0, lat_ct);
    run_op("exp1", 16'd20, 16'd1, 16'd7, 16'd6, 1'b0, lat_ct);
    run_op("base0", 16'd0, 16'd5, 16'd7, 16'd0, 1'b0, lat_ct);

    // New request accepted on the cycle done is high
    launch(16'd7, 16'd13, 16'd11);
    wait_done(t);
    chk("b2b_first", result, 16'd2);
    base = 16'd100; exponent = 16'd3; modulus = 16'd13; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_done_clear", done, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    wait_done(t);
    chk("b2b_second", result, 16'd1);
    if (lat_ct > 0) chk("b2b_latency", t, lat_ct);

    // Start while busy must be dropped
    launch(16'd7, 16'd13, 16'd11);
    repeat (20) @(posedge clk);
    @(negedge clk);
    base = 16'd3; exponent = 16'd2; modulus = 16'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(t);
    chk("busy_start_result", result, 16'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start_not_queued", busy, 1'b0);

    // Abort during the first MUL_B (edges 37..55 after accept)
    launch(16'd7, 16'd13, 16'd11);
    repeat (45) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, '0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (700) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_op("restart", 16'd7, 16'd13, 16'd11, 16'd2, 1'b0, lat_ct);

    // 256-bit encrypt then decrypt: 65^17 mod 3233 = 2790, 2790^2753 mod 3233 = 65
    @(negedge clk);
    enc_base = 256'd65; enc_exp = 12'd17; enc_mod = 256'd3233; enc_start = 1'b1;
    @(posedge clk);
    #1;
    enc_start = 1'b0;
    t = 0;
    while (enc_done !== 1'b1 && t < 10000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("enc_done_seen", enc_done, 1'b1);
    chk("enc_result", enc_result, 256'd2790);
    chk("enc_err", enc_err, 1'b0);
`ifndef RSA_EXP_SKIP_EN
    chk("enc_latency", t, 6452);
`endif
    dec_exp = 12'd2753; dec_start = 1'b1;
    @(posedge clk);
    #1;
    dec_start = 1'b0;
    chk("dec_busy", dec_busy, 1'b1);
    t = 0;
    while (dec_done !== 1'b1 && t < 10000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("dec_done_seen", dec_done, 1'b1);
    chk("dec_result", dec_result, 256'd65);
    chk("dec_err", dec_err, 1'b0);
    chk("enc_idle", enc_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
